gin_bus_fifo: RTL and testbench

Next-generation global input network bus. Accepts tagged packets over a valid/ready handshake and buffers them in a parametrised FIFO. Each packet is delivered to every controller whose scan-programmed ID matches its tag; the all-ones tag is a broadcast. Per-target ready/enable handshakes are tracked independently, so slow targets do not block delivery to ready ones. The block sits between the global buffer and the PE rows/columns.

---
 rtl/gin_bus_fifo.sv | 174 +++++++++++++++++
 tb/tb_gin_bus_fifo.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gin_bus_fifo.sv
`default_nettype none
// ============================================================================
// Module      : gin_bus_fifo
// Description : Global input network bus. Tagged packets enter through a
//               valid/ready handshake into a small FIFO, are popped into a
//               hold register, and are delivered to every controller whose
//               scan-programmed ID matches the tag (all-ones tag = broadcast).
//               Each target handshakes independently through a pending mask.
// Revision    : 1.0 - initial release
// ============================================================================
module gin_bus_fifo #(
    parameter int BITWIDTH        = 16,
    parameter int TAG_LENGTH      = 4,
    parameter int NUM_CONTROLLERS = 10,
    parameter int FIFO_DEPTH      = 4,
    parameter int CNT_WIDTH       = 8
) (
    input  logic                                clk,
    input  logic                                rstb,
    // Scan-chain shift enable ("program" is a reserved word in SystemVerilog)
    input  logic                                program_en,
    input  logic [TAG_LENGTH-1:0]               scan_tag_in,
    output logic [TAG_LENGTH-1:0]               scan_tag_out,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [TAG_LENGTH-1:0]               in_tag,
    input  logic [BITWIDTH-1:0]                 in_data,
    input  logic [NUM_CONTROLLERS-1:0]          target_ready,
    output logic [NUM_CONTROLLERS-1:0]          target_enable,
    output logic [BITWIDTH*NUM_CONTROLLERS-1:0] target_data,
    output logic [CNT_WIDTH-1:0]                drop_count,
    output logic                                idle
);

    localparam int                    c_ptr_w   = $clog2(FIFO_DEPTH);
    localparam int                    c_entry_w = TAG_LENGTH + BITWIDTH;
    localparam logic [TAG_LENGTH-1:0] c_bcast   = '1;
    localparam logic [CNT_WIDTH-1:0]  c_cnt_max = '1;
    localparam logic [CNT_WIDTH-1:0]  c_cnt_one = 1;
    localparam logic [c_ptr_w:0]      c_ptr_one = 1;

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_DELIVER = 1'b1
    } state_t;

    logic [TAG_LENGTH-1:0]      r_id [NUM_CONTROLLERS];
    logic [c_entry_w-1:0]       r_mem [FIFO_DEPTH];
    logic [c_ptr_w:0]           r_wr_ptr;
    logic [c_ptr_w:0]           r_rd_ptr;
    state_t                     r_state;
    state_t                     w_state_next;
    logic [NUM_CONTROLLERS-1:0] r_pending;
    logic [NUM_CONTROLLERS-1:0] w_pending_next;
    logic [NUM_CONTROLLERS-1:0] w_mask;
    logic [NUM_CONTROLLERS-1:0] w_enable;
    logic [BITWIDTH-1:0]        r_hold;
    logic [CNT_WIDTH-1:0]       r_drop_count;
    logic [TAG_LENGTH-1:0]      w_head_tag;
    logic [BITWIDTH-1:0]        w_head_data;
    logic                       w_full;
    logic                       w_empty;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_drop;

    // Extra pointer MSB distinguishes full from empty when the indices match
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]) &&
                      (r_wr_ptr[c_ptr_w-1:0] == r_rd_ptr[c_ptr_w-1:0]);
    assign in_ready = !w_full && !program_en;
    assign w_push   = in_valid && in_ready;
    // Pop only from IDLE; the whole FSM is frozen while the chain is shifting
    assign w_pop    = (r_state == S_IDLE) && !w_empty && !program_en;

    assign {w_head_tag, w_head_data} = r_mem[r_rd_ptr[c_ptr_w-1:0]];

    // Per-controller tag match against the FIFO head
    generate
        for (genvar g = 0; g < NUM_CONTROLLERS; g++) begin : g_mask
            assign w_mask[g] = (r_id[g] == w_head_tag) || (w_head_tag == c_bcast);
        end
    endgenerate

    // Every target sees the same hold register; target_enable qualifies it
    generate
        for (genvar g = 0; g < NUM_CONTROLLERS; g++) begin : g_slice
            assign target_data[g*BITWIDTH +: BITWIDTH] = r_hold;
        end
    endgenerate

    assign scan_tag_out  = r_id[NUM_CONTROLLERS-1];
    assign target_enable = w_enable;
    assign drop_count    = r_drop_count;
    assign idle          = w_empty && (r_state == S_IDLE);

    // ID scan chain: shift toward the highest index while program_en is high
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < NUM_CONTROLLERS; i++) r_id[i] <= '0;
        end else if (program_en) begin
            r_id[0] <= scan_tag_in;
            for (int i = 1; i < NUM_CONTROLLERS; i++) r_id[i] <= r_id[i-1];
        end
    end

    // Packet storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[c_ptr_w-1:0]] <= {in_tag, in_data};
    end

    // FIFO read/write pointers
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
        end
    end

    // FSM state, pending mask and hold register
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state   <= S_IDLE;
            r_pending <= '0;
            r_hold    <= '0;
        end else begin
            r_state   <= w_state_next;
            r_pending <= w_pending_next;
            if (w_pop) r_hold <= w_head_data;
        end
    end

    // Next state, pending update and Mealy target enables
    always_comb begin
        w_state_next   = r_state;
        w_pending_next = r_pending;
        w_enable       = '0;
        w_drop         = 1'b0;
        if (!program_en) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        if (w_mask == '0) begin
                            w_drop = 1'b1;
                        end else begin
                            w_pending_next = w_mask;
                            w_state_next   = S_DELIVER;
                        end
                    end
                end
                S_DELIVER: begin
                    w_enable       = r_pending & target_ready;
                    w_pending_next = r_pending & ~w_enable;
                    if (w_pending_next == '0) w_state_next = S_IDLE;
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Saturating count of packets that matched no controller
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_drop_count <= '0;
        end else if (w_drop && (r_drop_count != c_cnt_max)) begin
            r_drop_count <= r_drop_count + c_cnt_one;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gin_bus_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_gin_bus_fifo
// Description : Self-checking bench for gin_bus_fifo (4 controllers).
//               Table-driven single-packet vectors plus hand sequences for
//               partial readiness, back-pressure and mid-delivery reset.
//               A per-target scoreboard checks every enable pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gin_bus_fifo;

    localparam int BW = 16;
    localparam int TL = 4;
    localparam int NC = 4;
    localparam int FD = 4;
    localparam int CW = 8;

    logic             clk = 1'b0;
    logic             rstb;
    logic             program_en;
    logic [TL-1:0]    scan_tag_in;
    logic [TL-1:0]    scan_tag_out;
    logic             in_valid;
    logic             in_ready;
    logic [TL-1:0]    in_tag;
    logic [BW-1:0]    in_data;
    logic [NC-1:0]    target_ready;
    logic [NC-1:0]    target_enable;
    logic [BW*NC-1:0] target_data;
    logic [CW-1:0]    drop_count;
    logic             idle;

    gin_bus_fifo #(
        .BITWIDTH(BW), .TAG_LENGTH(TL), .NUM_CONTROLLERS(NC),
        .FIFO_DEPTH(FD), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rstb(rstb), .program_en(program_en),
        .scan_tag_in(scan_tag_in), .scan_tag_out(scan_tag_out),
        .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag), .in_data(in_data),
        .target_ready(target_ready), .target_enable(target_enable),
        .target_data(target_data), .drop_count(drop_count), .idle(idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TL-1:0] tag;
        logic [BW-1:0] data;
        logic [NC-1:0] exp_en;
    } vec_t;

    vec_t          vecs [7];
    int            n_vec = 0;
    int            n_err = 0;
    int            exp_drop = 0;
    logic [TL-1:0] model_id [NC];
    logic [BW-1:0] sbq [NC][$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NC-1:0] model_mask(input logic [TL-1:0] tag);
        logic [NC-1:0] m;
        for (int i = 0; i < NC; i++) m[i] = (model_id[i] == tag) || (tag == 4'hF);
        return m;
    endfunction

    function automatic bit sb_empty();
        for (int i = 0; i < NC; i++) if (sbq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Record an accepted packet: expected deliveries or an expected drop
    task automatic sb_push(input logic [TL-1:0] tag, input logic [BW-1:0] data);
        logic [NC-1:0] m;
        m = model_mask(tag);
        if (m == '0) begin
            if (exp_drop < 255) exp_drop++;
        end else begin
            for (int i = 0; i < NC; i++) if (m[i]) sbq[i].push_back(data);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic model_shift(input logic [TL-1:0] v);
        for (int i = NC - 1; i > 0; i--) model_id[i] = model_id[i-1];
        model_id[0] = v;
    endtask

    // Shift four IDs in; the first value ends up in id[3]
    task automatic prog4(input logic [TL-1:0] v0, input logic [TL-1:0] v1,
                         input logic [TL-1:0] v2, input logic [TL-1:0] v3);
        logic [TL-1:0] vals [4];
        vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
        for (int k = 0; k < 4; k++) begin
            step();
            if (k > 0) model_shift(vals[k-1]);
            program_en  = 1'b1;
            scan_tag_in = vals[k];
            settle();
            chk("prog_in_ready_low", in_ready, 0);
            chk("prog_scan_out", scan_tag_out, model_id[NC-1]);
            chk("prog_no_enable", target_enable, 0);
        end
        step();
        model_shift(vals[3]);
        program_en = 1'b0;
        settle();
        chk("prog_scan_out_final", scan_tag_out, model_id[NC-1]);
    endtask

    task automatic apply_vec(input vec_t v);
        step();
        in_valid = 1'b1; in_tag = v.tag; in_data = v.data;
        settle();
        chk("vec_in_ready", in_ready, 1);
        if (in_ready) sb_push(v.tag, v.data);
        step();
        in_valid = 1'b0;
        step();
        settle();
        chk("vec_enable", target_enable, v.exp_en);
        chk("vec_drop_count", drop_count, exp_drop);
        if (v.exp_en != '0) chk("vec_data", target_data, {NC{v.data}});
        step();
        settle();
        chk("vec_enable_cleared", target_enable, 0);
        chk("vec_idle", idle, 1);
    endtask

    task automatic wait_idle(input int bound, input string name);
        int k;
        k = 0;
        while (!(idle === 1'b1 && target_enable == '0 && sb_empty()) && k < bound) begin
            step();
            k++;
        end
        chk(name, idle, 1);
    endtask

    // Scoreboard monitor: every enable must carry the next expected payload
    always @(negedge clk) begin
        logic [BW-1:0] e;
        if (rstb === 1'b1 && target_enable != '0) begin
            chk("enable_without_ready", target_enable & ~target_ready, 0);
            for (int i = 0; i < NC; i++) begin
                if (target_enable[i]) begin
                    if (sbq[i].size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL sb_unexpected_enable: target %0d got %0h, required no enable",
                                 i, target_data[i*BW +: BW]);
                    end else begin
                        e = sbq[i].pop_front();
                        chk("sb_data", target_data[i*BW +: BW], e);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        int idx;
        int k;
        int left;
        logic [TL-1:0] tags5 [6];

        rstb = 1'b0; program_en = 1'b0; scan_tag_in = '0;
        in_valid = 1'b0; in_tag = '0; in_data = '0; target_ready = '0;
        for (int i = 0; i < NC; i++) model_id[i] = '0;

        vecs[0] = '{tag: 4'h2, data: 16'hBEEF, exp_en: 4'b0100};
        vecs[1] = '{tag: 4'h0, data: 16'h0001, exp_en: 4'b0001};
        vecs[2] = '{tag: 4'h3, data: 16'h3333, exp_en: 4'b1000};
        vecs[3] = '{tag: 4'hF, data: 16'hA5A5, exp_en: 4'b1111};
        vecs[4] = '{tag: 4'h9, data: 16'h0999, exp_en: 4'b0000};
        vecs[5] = '{tag: 4'h1, data: 16'h1111, exp_en: 4'b0010};
        vecs[6] = '{tag: 4'h7, data: 16'h0777, exp_en: 4'b0000};

        // Reset state
        repeat (2) step();
        settle();
        chk("rst_idle", idle, 1);
        chk("rst_enable", target_enable, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_scan_out", scan_tag_out, 0);
        chk("rst_data", target_data, 0);
        chk("rst_in_ready", in_ready, 1);
        step();
        rstb = 1'b1;

        // Program IDs 0,1,2,3 then run the single-packet table
        prog4(4'h3, 4'h2, 4'h1, 4'h0);
        target_ready = 4'hF;
        for (int v = 0; v < 7; v++) apply_vec(vecs[v]);

        // Partial readiness with duplicate IDs 5,5,7,5
        prog4(4'h5, 4'h7, 4'h5, 4'h5);
        target_ready = 4'b0001;
        step();
        in_valid = 1'b1; in_tag = 4'h5; in_data = 16'h1234;
        settle();
        chk("dup_in_ready", in_ready, 1);
        if (in_ready) sb_push(4'h5, 16'h1234);
        step();
        in_valid = 1'b0;
        step(); settle();
        chk("dup_en_first", target_enable, 4'b0001);
        chk("dup_data_first", target_data, {NC{16'h1234}});
        step(); settle();
        chk("dup_en_wait", target_enable, 4'b0000);
        chk("dup_data_stable", target_data, {NC{16'h1234}});
        chk("dup_not_idle", idle, 0);
        step();
        target_ready = 4'hF;
        settle();
        chk("dup_en_rest", target_enable, 4'b1010);
        step(); settle();
        chk("dup_en_done", target_enable, 0);
        chk("dup_idle", idle, 1);

        // Drop counter saturation with IDs 0..3 and unmatched tag 9
        prog4(4'h3, 4'h2, 4'h1, 4'h0);
        acc = 0; k = 0;
        while (acc < 300 && k < 400) begin
            step();
            in_valid = 1'b1; in_tag = 4'h9; in_data = 16'(acc);
            settle();
            if (in_ready) begin
                sb_push(4'h9, 16'(acc));
                acc++;
            end
            k++;
        end
        step();
        in_valid = 1'b0;
        chk("sat_accepted", acc, 300);
        wait_idle(20, "sat_wait_idle");
        chk("sat_drop_count", drop_count, exp_drop);

        // Back-pressure: no targets ready, six packets offered
        tags5[0] = 4'h2; tags5[1] = 4'h2; tags5[2] = 4'hF;
        tags5[3] = 4'h2; tags5[4] = 4'h2; tags5[5] = 4'h2;
        target_ready = 4'h0;
        idx = 0; acc = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            in_valid = 1'b1; in_tag = tags5[idx]; in_data = 16'h5000 + 16'(idx);
            settle();
            if (in_ready) begin
                sb_push(tags5[idx], 16'h5000 + 16'(idx));
                acc++;
                if (idx < 5) idx++;
            end
        end
        chk("bp_accepted", acc, 5);
        chk("bp_in_ready_low", in_ready, 0);
        step();
        in_valid = 1'b0;
        target_ready = 4'hF;
        settle();
        chk("bp_still_full", in_ready, 0);
        k = 0;
        while (in_ready !== 1'b1 && k < 4) begin
            step();
            k++;
        end
        chk("bp_in_ready_rises", in_ready, 1);
        wait_idle(50, "bp_wait_idle");

        // Reset in the middle of a delivery with pending = 0110
        target_ready = 4'b1001;
        step();
        in_valid = 1'b1; in_tag = 4'hF; in_data = 16'hC0DE;
        settle();
        if (in_ready) sb_push(4'hF, 16'hC0DE);
        step();
        in_valid = 1'b0;
        step(); settle();
        chk("mrst_en_partial", target_enable, 4'b1001);
        in_valid = 1'b1; in_tag = 4'h0; in_data = 16'h0BAD;
        if (in_ready) sb_push(4'h0, 16'h0BAD);
        step();
        in_valid = 1'b0;
        target_ready = 4'h0;
        settle();
        chk("mrst_en_blocked", target_enable, 0);
        chk("mrst_busy", idle, 0);
        step();
        target_ready = 4'hF;
        rstb = 1'b0;
        settle();
        for (int i = 0; i < NC; i++) begin
            sbq[i].delete();
            model_id[i] = '0;
        end
        exp_drop = 0;
        chk("mrst_enable", target_enable, 0);
        chk("mrst_idle", idle, 1);
        chk("mrst_drop", drop_count, 0);
        chk("mrst_in_ready", in_ready, 1);
        chk("mrst_data", target_data, 0);
        chk("mrst_scan_out", scan_tag_out, 0);
        step();
        rstb = 1'b1;
        repeat (3) begin
            step(); settle();
            chk("mrst_no_enable", target_enable, 0);
        end
        // All IDs are zero again: tag 0 reaches every controller
        apply_vec('{tag: 4'h0, data: 16'h7777, exp_en: 4'b1111});
        apply_vec('{tag: 4'h5, data: 16'h0555, exp_en: 4'b0000});

        left = 0;
        for (int i = 0; i < NC; i++) left += sbq[i].size();
        chk("sb_leftover", left, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
